// File: rtl/add_round_key_col.sv
`default_nettype none
// ============================================================================
// Module      : add_round_key_col
// Description : AES AddRoundKey stage placed after MixColumns. It takes the
//               four mixed columns of one state serially, XORs each column with
//               the matching round-key word, and presents the assembled 128-bit
//               state under a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module add_round_key_col #(
  parameter int NCOL   = 4,   // columns per state (AES-128: always 4)
  parameter int WORD_W = 32   // column width in bits
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [WORD_W-1:0]          col_in,
  input  logic                       col_valid,
  output logic                       col_ready,
  input  logic [NCOL*WORD_W-1:0]     rkey,
  input  logic                       rkey_valid,
  output logic [$clog2(NCOL)-1:0]    col_idx,
  output logic [NCOL*WORD_W-1:0]     state_out,
  output logic                       state_valid,
  input  logic                       state_ready
);

  localparam int STATE_W = NCOL * WORD_W;
  localparam int IDX_W   = $clog2(NCOL);
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NCOL - 1);
  localparam logic [IDX_W-1:0] c_IDX_ZERO = '0;
  localparam logic [IDX_W-1:0] c_IDX_ONE  = IDX_W'(1);

  // IDLE: waiting for column 0; COLLECT: columns 1..NCOL-1; HOLD: state presented
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_col_idx;
  logic [STATE_W-1:0]  r_key;
  logic [STATE_W-1:0]  r_state_out;
  logic                r_state_valid;

  logic                w_ready_st;
  logic                w_accept;
  logic                w_out_hs;
  logic [WORD_W-1:0]   w_key_word [NCOL];
  logic [WORD_W-1:0]   w_key_sel;
  logic [WORD_W-1:0]   w_col_xor;
  logic [NCOL-1:0]     w_word_we;

  // Split the latched key into words; word k sits at the MSB end for k = 0
  for (genvar k = 0; k < NCOL; k++) begin : g_key_word
    assign w_key_word[k] = r_key[STATE_W-1-k*WORD_W -: WORD_W];
  end

  // Column 0 is XORed with the live key (it is latched on the same edge);
  // later columns use the key captured with column 0 so rkey may change freely.
  assign w_key_sel = (r_state == S_IDLE) ? rkey[STATE_W-1 -: WORD_W]
                                         : w_key_word[r_col_idx];
  assign w_col_xor = col_in ^ w_key_sel;

  // Ready depends only on the FSM state (and key availability for column 0)
  always_comb begin
    w_ready_st = 1'b0;
    case (r_state)
      S_IDLE:    w_ready_st = rkey_valid;
      S_COLLECT: w_ready_st = 1'b1;
      S_HOLD:    w_ready_st = 1'b0;
      default:   w_ready_st = 1'b0;
    endcase
  end

  // Gate with rst_n so nothing is advertised while reset is held
  assign col_ready = w_ready_st & rst_n;

  // A flush in the same cycle wins over a column handshake
  assign w_accept = col_valid & col_ready & ~flush;
  assign w_out_hs = r_state_valid & state_ready;

  // One write-enable per output word, selected by the current column index
  for (genvar k = 0; k < NCOL; k++) begin : g_word_we
    assign w_word_we[k] = w_accept && (r_col_idx == IDX_W'(k));
  end

  // FSM, column counter, key capture and output assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_col_idx     <= c_IDX_ZERO;
      r_key         <= '0;
      r_state_out   <= '0;
      r_state_valid <= 1'b0;
    end else begin
      if (flush) begin
        r_state       <= S_IDLE;
        r_col_idx     <= c_IDX_ZERO;
        r_state_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_key     <= rkey;
              r_col_idx <= c_IDX_ONE;
              r_state   <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            if (w_accept) begin
              if (r_col_idx == c_LAST_IDX) begin
                r_col_idx     <= c_IDX_ZERO;
                r_state       <= S_HOLD;
                r_state_valid <= 1'b1;
              end else begin
                r_col_idx <= IDX_W'(r_col_idx + c_IDX_ONE);
              end
            end
          end
          S_HOLD: begin
            // Only the output handshake can leave HOLD; col_ready is low here
            if (w_out_hs) begin
              r_state_valid <= 1'b0;
              r_state       <= S_IDLE;
            end
          end
          default: begin
            r_state       <= S_IDLE;
            r_col_idx     <= c_IDX_ZERO;
            r_state_valid <= 1'b0;
          end
        endcase
      end

      // Unwritten words keep their previous contents; state_valid qualifies
      for (int k = 0; k < NCOL; k++) begin
        if (w_word_we[k]) begin
          r_state_out[STATE_W-1-k*WORD_W -: WORD_W] <= w_col_xor;
        end
      end
    end
  end

  assign col_idx     = r_col_idx;
  assign state_out   = r_state_out;
  assign state_valid = r_state_valid;

`ifndef SYNTHESIS
  // Presented state must not change while downstream stalls
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state_valid && !state_ready && !flush) |=> (r_state_valid && $stable(r_state_out)));

  // No column may be taken while a full state is being presented
  a_no_accept_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    r_state_valid |-> !col_ready);

  // state_valid is asserted exactly when the FSM sits in HOLD
  a_valid_matches_hold: assert property (@(posedge clk) disable iff (!rst_n)
    r_state_valid == (r_state == S_HOLD));

  // Column index is zero whenever the FSM is not collecting
  a_idx_zero_outside_collect: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state != S_COLLECT) |-> (r_col_idx == c_IDX_ZERO));
`endif

endmodule
`default_nettype wire

// File: doc/add_round_key_col.md
Name: add_round_key_col

Overview:
- Encryption-round stage directly downstream of MixColumns.
- Accepts the four 32-bit mixed columns of one AES state serially, one per handshake.
- XORs each column with the matching 32-bit word of the 128-bit round key and assembles the 128-bit round output.
- Presents the assembled state downstream under a valid/ready handshake; the next round (SubBytes) consumes it.

Parameters:
- NCOL, 4, columns per state; fixed at 4 for AES-128, not to be overridden.
- WORD_W, 32, column width in bits; state width = NCOL*WORD_W = 128.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous deassert.
- flush  in  1  synchronous abort; discards the partial state and returns to IDLE.
- col_in  in  32  mixed column, byte 0 of the column in bits [31:24].
- col_valid  in  1  col_in is valid.
- col_ready  out  1  stage accepts col_in this cycle.
- rkey  in  128  round key; word k is in bits [127-32k -: 32].
- rkey_valid  in  1  rkey is valid; sampled only when column 0 is accepted.
- col_idx  out  2  index of the next column to be accepted.
- state_out  out  128  assembled round state; column k is in bits [127-32k -: 32].
- state_valid  out  1  state_out holds a complete state.
- state_ready  in  1  downstream accepts state_out.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = IDLE, col_idx = 0.
  - state_out = 0, state_valid = 0, key register = 0.
  - col_ready = 0 while reset is asserted.
- States: IDLE (no column yet), COLLECT (1..3 columns taken), HOLD (full state presented).
- col_ready is combinational:
  - IDLE: rkey_valid.
  - COLLECT: 1.
  - HOLD: 0.
- Accept = col_valid & col_ready. Column 0 is never taken without a valid key.
- Accept in IDLE:
  - key register <= rkey.
  - state_out[127:96] <= col_in ^ rkey[127:96].
  - col_idx <= 1, go to COLLECT.
- Accept in COLLECT with col_idx = k:
  - state_out word k <= col_in ^ key_reg word k.
  - rkey changes after column 0 have no effect.
- Accept with k = 3:
  - col_idx wraps to 0, go to HOLD.
  - state_valid = 1 on the next cycle.
  - Latency from the last column handshake to state_valid is 1 cycle.
- HOLD:
  - state_out and state_valid are held stable until state_ready = 1.
  - On state_valid & state_ready: state_valid <= 0, go to IDLE.
  - A new column 0 may be accepted no earlier than the cycle after the output handshake.
  - Throughput is one state per 5 cycles with no stalls.
- No column is dropped or duplicated on col_valid gaps; col_idx advances only on accept.
- state_out words not yet written in the current state retain their previous values. Only state_valid qualifies the data.
- flush = 1:
  - Next state IDLE, col_idx = 0, state_valid = 0.
  - A column presented in the same cycle is not accepted; flush overrides accept.
  - flush in HOLD drops the presented state even if state_ready = 1.
- rst_n low mid-operation: immediate return to reset values; partial state is discarded.
- Simultaneous state_ready and col_valid in HOLD: only the output handshake completes.
- Pure XOR datapath; no carries, widths exact, no truncation.

Test Plan:
- FIPS-197 round 1: rkey = a0fafe17_88542cb1_23a33939_2a6c7605, rkey_valid = 1; columns 046681e5, e0cb199a, 48f8d37a, 2806264c on consecutive cycles -> col_ready high for 4 cycles; state_valid on cycle 5; state_out = a49c7ff2_689f352b_6b5bea43_026a5049.
- Key gating: rkey_valid = 0 with col_valid = 1 in IDLE -> col_ready = 0, col_idx stays 0. Raising rkey_valid -> column accepted next cycle. Changing rkey after column 0 -> output unchanged from the above vector.
- Back-pressure: state_ready = 0 for 6 cycles after state_valid -> state_out stable, col_ready = 0, no new column taken. state_ready = 1 -> state_valid drops next cycle; IDLE accepts the next state.
- Gaps: same vectors with col_valid deasserted 2 cycles between each column -> identical state_out; col_idx sequence 0,1,2,3,0.
- flush after 2 columns -> col_idx = 0, state_valid never asserts. Next full 4-column sequence produces the correct result with no stale words from the aborted state.
- Async reset: assert rst_n = 0 between clock edges in HOLD -> state_valid and state_out go to 0 immediately, without waiting for a clock edge. After deassert -> IDLE, col_ready = rkey_valid.
